// File: rtl/reg_2bytes_uart_rx.sv
// Two-byte frame assembler on the receive side of the UART link.
// Pairs consecutive bytes from the UART RX core into (byte_one, byte_two),
// pulses valid_o when a frame completes, and drops a half frame with a
// timeout_err_o pulse if the second byte is late.
//
// state          | meaning
// S_IDLE         | no byte held; a rising rx_done with enable captures byte one
// S_WAIT_SECOND  | byte one held, counting cycles until byte two or timeout
module reg_2bytes_uart_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 104166
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  output logic [7:0] byte_one_o,
  output logic [7:0] byte_two_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE        = 1'b0,
    S_WAIT_SECOND = 1'b1
  } state_e;

  state_e        state_q;
  logic          rx_done_q;
  logic [7:0]    first_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    byte_one_q;
  logic [7:0]    byte_two_q;
  logic          valid_q;
  logic          busy_q;
  logic          timeout_q;
  logic          byte_evt;

  // Only the rising edge of rx_done marks a new byte, so a held level counts once.
  always_comb begin
    byte_evt = rx_done_i & ~rx_done_q;
    cnt_d    = cnt_q + 1'b1;
  end

  // Frame sequencer; all outputs are registered alongside the state.
  // The counter cannot wrap: reaching CNT_LAST always leaves S_WAIT_SECOND.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rx_done_q  <= 1'b0;
      first_q    <= '0;
      cnt_q      <= '0;
      byte_one_q <= '0;
      byte_two_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      rx_done_q <= rx_done_i;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (byte_evt && enable_i) begin
            first_q <= rx_data_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_SECOND;
          end
        end
        S_WAIT_SECOND: begin
          cnt_q <= cnt_d;
          // A byte arriving on the terminal cycle still completes the frame.
          if (byte_evt) begin
            byte_one_q <= first_q;
            byte_two_q <= rx_data_i;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            first_q   <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_one_o    = byte_one_q;
  assign byte_two_o    = byte_two_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_reg_2bytes_uart_rx.sv
// Bench for reg_2bytes_uart_rx with a 20-cycle inter-byte timeout.
module tb_reg_2bytes_uart_rx;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] byte_one, byte_two;
  logic       valid, busy, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_to     = 0;
  bit saw_ee   = 1'b0;

  // Behavioural expectation: a pending first byte with its age in cycles.
  bit       m_pending = 1'b0;
  bit       m_prev_done = 1'b0;
  int       m_age = 0;
  bit [7:0] m_first = 8'h00;
  bit [7:0] e_b1 = 8'h00, e_b2 = 8'h00;
  bit       e_valid = 1'b0, e_busy = 1'b0, e_to = 1'b0;

  reg_2bytes_uart_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .rx_data_i    (rx_data),
    .rx_done_i    (rx_done),
    .byte_one_o   (byte_one),
    .byte_two_o   (byte_two),
    .valid_o      (valid),
    .busy_o       (busy),
    .timeout_err_o(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pending = 0; m_prev_done = 0; m_age = 0; m_first = 0;
    e_b1 = 0; e_b2 = 0; e_valid = 0; e_busy = 0; e_to = 0;
  endtask

  // One clock of the frame rules: a frame is a first byte followed by a second
  // byte no more than T cycles later; otherwise the first byte is dropped.
  task automatic model_step();
    bit evt;
    evt = rx_done && !m_prev_done;
    m_prev_done = rx_done;
    e_valid = 0;
    e_to = 0;
    if (!m_pending) begin
      if (evt && enable) begin
        m_pending = 1; m_first = rx_data; m_age = 0;
      end
    end else begin
      m_age++;
      if (evt) begin
        e_b1 = m_first; e_b2 = rx_data; e_valid = 1; m_pending = 0;
      end else if (m_age >= T) begin
        e_to = 1; m_pending = 0;
      end
    end
    e_busy = m_pending;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison, half a period after the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_byte_one", byte_one, e_b1);
      chk("cmp_byte_two", byte_two, e_b2);
      chk("cmp_valid", valid, e_valid);
      chk("cmp_busy", busy, e_busy);
      chk("cmp_timeout_err", timeout_err, e_to);
      if (valid) n_valid++;
      if (timeout_err) n_to++;
      if (byte_one == 8'hEE || byte_two == 8'hEE) saw_ee = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, t0;
    #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("reset_byte_one", byte_one, 8'h00);
    chk("reset_busy", busy, 1'b0);

    // 1: basic frame, bytes 10 cycles apart
    enable = 1'b1;
    v0 = n_valid;
    send_byte(8'hA5, 1);
    chk("t1_busy_between", busy, 1'b1);
    idle(8);
    send_byte(8'h3C, 1);
    chk("t1_valid_latency", valid, 1'b1);
    idle(2);
    chk("t1_byte_one", byte_one, 8'hA5);
    chk("t1_byte_two", byte_two, 8'h3C);
    chk("t1_frames", n_valid - v0, 1);

    // 2: level-held rx_done counts once per byte
    v0 = n_valid;
    send_byte(8'h11, 5);
    send_byte(8'h22, 5);
    idle(4);
    chk("t2_frames", n_valid - v0, 1);
    chk("t2_byte_one", byte_one, 8'h11);
    chk("t2_byte_two", byte_two, 8'h22);

    // 3: lone byte times out 20 cycles after capture
    t0 = n_to;
    send_byte(8'h55, 1);
    idle(T - 1);
    chk("t3_no_early_timeout", timeout_err, 1'b0);
    chk("t3_busy_before_timeout", busy, 1'b1);
    idle(1);
    chk("t3_timeout_pulse", timeout_err, 1'b1);
    chk("t3_busy_after_timeout", busy, 1'b0);
    idle(2);
    chk("t3_timeouts", n_to - t0, 1);
    chk("t3_keep_byte_one", byte_one, 8'h11);
    chk("t3_keep_byte_two", byte_two, 8'h22);
    send_byte(8'h01, 1);
    idle(3);
    send_byte(8'h02, 1);
    idle(1);
    chk("t3_byte_one", byte_one, 8'h01);
    chk("t3_byte_two", byte_two, 8'h02);

    // 4: second byte sampled on the terminal cycle
    t0 = n_to;
    send_byte(8'hC3, 1);
    idle(T - 2);
    send_byte(8'h5A, 1);
    chk("t4_valid_on_terminal", valid, 1'b1);
    chk("t4_no_timeout", timeout_err, 1'b0);
    idle(2);
    chk("t4_timeouts", n_to - t0, 0);
    chk("t4_byte_one", byte_one, 8'hC3);
    chk("t4_byte_two", byte_two, 8'h5A);

    // 5: disabled byte is dropped
    enable = 1'b0;
    v0 = n_valid;
    send_byte(8'h77, 1);
    chk("t5_busy_disabled", busy, 1'b0);
    idle(3);
    enable = 1'b1;
    send_byte(8'h88, 1);
    idle(4);
    send_byte(8'h99, 1);
    idle(1);
    chk("t5_frames", n_valid - v0, 1);
    chk("t5_byte_one", byte_one, 8'h88);
    chk("t5_byte_two", byte_two, 8'h99);

    // 6: reset in the middle of a frame
    send_byte(8'hEE, 1);
    chk("t6_busy_pending", busy, 1'b1);
    idle(2);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_byte_one", byte_one, 8'h00);
    chk("t6_async_byte_two", byte_two, 8'h00);
    idle(2);
    reset = 1'b0;
    send_byte(8'h12, 1);
    idle(2);
    send_byte(8'h34, 1);
    idle(1);
    chk("t6_byte_one", byte_one, 8'h12);
    chk("t6_byte_two", byte_two, 8'h34);
    idle(3);
    chk("t6_no_ee", saw_ee, 1'b0);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
